// File: rtl/channel_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// channel_tx : PRBS7 excitation source feeding a 3-tap FIR channel model
// Rev 1.0
// ---------------------------------------------------------------------------
module channel_tx #(
   parameter int NB_DATA = 16,
   parameter int NB_DIV  = 8,
   parameter int NB_CNT  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_coef_valid,
   input  logic [NB_DATA-1:0] i_coef,
   output logic               o_coef_ready,
   input  logic [NB_DIV-1:0]  i_div,
   input  logic [NB_CNT-1:0]  i_nsamples,
   output logic [NB_DATA-1:0] o_x,
   output logic [NB_DATA-1:0] o_d,
   output logic               o_valid,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [6:0]                C_LFSR_SEED = 7'h7F;
   localparam logic signed [NB_DATA-1:0] C_X_POS = {2'b01, {(NB_DATA-2){1'b0}}};
   localparam logic signed [NB_DATA-1:0] C_X_NEG = {2'b11, {(NB_DATA-2){1'b0}}};

   function automatic logic signed [NB_DATA-1:0] sat(input logic signed [NB_DATA:0] v);
      if (v[NB_DATA] != v[NB_DATA-1])
         sat = v[NB_DATA] ? {1'b1, {(NB_DATA-1){1'b0}}} : {1'b0, {(NB_DATA-1){1'b1}}};
      else
         sat = v[NB_DATA-1:0];
   endfunction

   // Full-precision product, keep Q(NB_DATA,NB_DATA-1) by dropping LSBs (floor), then clamp.
   function automatic logic signed [NB_DATA-1:0] mul_q(input logic signed [NB_DATA-1:0] a,
                                                       input logic signed [NB_DATA-1:0] b);
      logic signed [2*NB_DATA-1:0] p;
      p     = a * b;
      mul_q = sat(p[2*NB_DATA-1:NB_DATA-1]);
   endfunction

   state_t                    state_q, state_d;
   logic [6:0]                lfsr_q, lfsr_d;
   logic [1:0]                idx_q, idx_d;
   logic [NB_DIV-1:0]         div_lat_q, div_lat_d, div_cnt_q, div_cnt_d;
   logic [NB_CNT-1:0]         ns_lat_q, ns_lat_d, samp_cnt_q, samp_cnt_d;
   logic signed [NB_DATA-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
   logic signed [NB_DATA-1:0] hx1_q, hx1_d, hx2_q, hx2_d;
   logic signed [NB_DATA-1:0] x_q, x_d, d_q, d_d;
   logic                      valid_q, valid_d, busy_q, busy_d;
   logic                      done_q, done_d, ready_q, ready_d;

   logic signed [NB_DATA-1:0] w_x0, w_p0, w_p1, w_p2, w_s01, w_dnew;
   logic [NB_CNT-1:0]         w_cnt_inc;
   logic                      w_coef_hs;

   assign w_x0      = lfsr_q[6] ? C_X_POS : C_X_NEG;
   assign w_p0      = mul_q(h0_q, w_x0);
   assign w_p1      = mul_q(h1_q, hx1_q);
   assign w_p2      = mul_q(h2_q, hx2_q);
   assign w_s01     = sat({w_p0[NB_DATA-1], w_p0} + {w_p1[NB_DATA-1], w_p1});
   assign w_dnew    = sat({w_s01[NB_DATA-1], w_s01} + {w_p2[NB_DATA-1], w_p2});
   assign w_cnt_inc = samp_cnt_q + NB_CNT'(1);
   assign w_coef_hs = i_coef_valid && ready_q;

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      idx_d      = idx_q;
      div_lat_d  = div_lat_q;
      div_cnt_d  = div_cnt_q;
      ns_lat_d   = ns_lat_q;
      samp_cnt_d = samp_cnt_q;
      h0_d       = h0_q;
      h1_d       = h1_q;
      h2_d       = h2_q;
      hx1_d      = hx1_q;
      hx2_d      = hx2_q;
      x_d        = x_q;
      d_d        = d_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_coef_hs) begin
               case (idx_q)
                  2'd0:    h0_d = i_coef;
                  2'd1:    h1_d = i_coef;
                  default: h2_d = i_coef;
               endcase
               idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
            if (i_start && !i_stop) begin
               state_d    = ST_RUN;
               div_lat_d  = i_div;
               ns_lat_d   = i_nsamples;
               lfsr_d     = C_LFSR_SEED;
               div_cnt_d  = '0;
               samp_cnt_d = '0;
               hx1_d      = '0;
               hx2_d      = '0;
            end
         end
         ST_RUN: begin
            if (i_stop) begin
               state_d = ST_IDLE;
            end else if (div_cnt_q == div_lat_q) begin
               div_cnt_d  = '0;
               lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
               x_d        = w_x0;
               d_d        = w_dnew;
               valid_d    = 1'b1;
               hx1_d      = w_x0;
               hx2_d      = hx1_q;
               samp_cnt_d = w_cnt_inc;
               if (ns_lat_q != '0 && w_cnt_inc == ns_lat_q)
                  state_d = ST_DONE;
            end else begin
               div_cnt_d = div_cnt_q + NB_DIV'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = !i_stop;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && state_d == ST_IDLE)
         idx_d = 2'd0;
      busy_d  = (state_d == ST_RUN);
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         lfsr_q     <= C_LFSR_SEED;
         idx_q      <= 2'd0;
         div_lat_q  <= '0;
         div_cnt_q  <= '0;
         ns_lat_q   <= '0;
         samp_cnt_q <= '0;
         h0_q       <= '0;
         h1_q       <= '0;
         h2_q       <= '0;
         hx1_q      <= '0;
         hx2_q      <= '0;
         x_q        <= '0;
         d_q        <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         idx_q      <= idx_d;
         div_lat_q  <= div_lat_d;
         div_cnt_q  <= div_cnt_d;
         ns_lat_q   <= ns_lat_d;
         samp_cnt_q <= samp_cnt_d;
         h0_q       <= h0_d;
         h1_q       <= h1_d;
         h2_q       <= h2_d;
         hx1_q      <= hx1_d;
         hx2_q      <= hx2_d;
         x_q        <= x_d;
         d_q        <= d_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   assign o_x          = x_q;
   assign o_d          = d_q;
   assign o_valid      = valid_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_coef_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_tx.sv
`default_nettype none
// tb_channel_tx : directed, table-driven checks of the channel_tx frame engine.
module tb_channel_tx;

   logic        clk;
   logic        rst;
   logic        i_start, i_stop, i_coef_valid;
   logic [15:0] i_coef;
   logic [7:0]  i_div;
   logic [15:0] i_nsamples;
   logic [15:0] o_x, o_d;
   logic        o_valid, o_busy, o_done, o_coef_ready;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [15:0]      h0;
      logic [15:0]      h1;
      logic [15:0]      h2;
      logic [7:0]       div;
      logic [15:0]      ns;
      logic [0:2][15:0] ex;
      logic [0:2][15:0] ed;
   } vec_t;

   vec_t        vecs  [5];
   logic [15:0] run1  [12];
   logic [15:0] x_ref [12];

   channel_tx #(.NB_DATA(16), .NB_DIV(8), .NB_CNT(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .i_coef_valid (i_coef_valid),
      .i_coef       (i_coef),
      .o_coef_ready (o_coef_ready),
      .i_div        (i_div),
      .i_nsamples   (i_nsamples),
      .o_x          (o_x),
      .o_d          (o_d),
      .o_valid      (o_valid),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check16({tag, " o_x"}, o_x, 16'h0000);
      check16({tag, " o_d"}, o_d, 16'h0000);
      check1({tag, " o_valid"}, o_valid, 1'b0);
      check1({tag, " o_busy"}, o_busy, 1'b0);
      check1({tag, " o_done"}, o_done, 1'b0);
      check1({tag, " o_coef_ready"}, o_coef_ready, 1'b0);
   endtask

   task automatic wr(input logic [15:0] v);
      i_coef_valid = 1'b1;
      i_coef       = v;
      tick();
      i_coef_valid = 1'b0;
   endtask

   // Start a frame (optionally writing one coefficient in the start cycle) and
   // check every cycle's strobe timing plus the sample values.
   task automatic run_frame(input string tag, input logic [7:0] div, input logic [15:0] ns,
                            input logic wr_last, input logic [15:0] last_coef,
                            input logic [0:2][15:0] ex, input logic [0:2][15:0] ed);
      int   period;
      int   last;
      int   k;
      logic exp_v;
      period       = int'(div) + 1;
      last         = period * int'(ns);
      k            = 0;
      i_div        = div;
      i_nsamples   = ns;
      i_coef_valid = wr_last;
      i_coef       = last_coef;
      i_start      = 1'b1;
      tick();
      i_coef_valid = 1'b0;
      i_start      = 1'b0;
      check1({tag, " busy"}, o_busy, 1'b1);
      for (int c = 1; c <= last + 1; c++) begin
         tick();
         exp_v = (c % period == 0) && (c <= last);
         check1({tag, " valid"}, o_valid, exp_v);
         check1({tag, " done"}, o_done, c == last + 1);
         if (exp_v && k < 3) begin
            check16({tag, " x"}, o_x, ex[k]);
            check16({tag, " d"}, o_d, ed[k]);
            k++;
         end
      end
      check1({tag, " ready"}, o_coef_ready, 1'b1);
   endtask

   initial begin
      int k;
      //           h0        h1        h2        div    ns     x[0..2]                          d[0..2]
      vecs[0] = '{16'h4000, 16'h2000, 16'h0000, 8'd0, 16'd3, {16'h4000, 16'h4000, 16'h4000}, {16'h2000, 16'h3000, 16'h3000}};
      vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 8'd0, 16'd3, {16'h4000, 16'h4000, 16'h4000}, {16'h3FFF, 16'h7FFE, 16'h7FFF}};
      vecs[2] = '{16'h8000, 16'h8000, 16'h8000, 8'd0, 16'd3, {16'h4000, 16'h4000, 16'h4000}, {16'hC000, 16'h8000, 16'h8000}};
      vecs[3] = '{16'h2000, 16'hE000, 16'h1000, 8'd4, 16'd2, {16'h4000, 16'h4000, 16'h0000}, {16'h1000, 16'h0000, 16'h0000}};
      vecs[4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 8'd2, 16'd3, {16'h4000, 16'h4000, 16'h4000}, {16'h3FFF, 16'hFFFF, 16'hFFFE}};
      for (int i = 0; i < 12; i++) x_ref[i] = (i < 7) ? 16'h4000 : 16'hC000;

      rst          = 1'b1;
      i_start      = 1'b0;
      i_stop       = 1'b0;
      i_coef_valid = 1'b0;
      i_coef       = 16'h0000;
      i_div        = 8'd0;
      i_nsamples   = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check1("ready after release", o_coef_ready, 1'b1);

      for (int i = 0; i < 5; i++) begin
         wr(vecs[i].h0);
         wr(vecs[i].h1);
         run_frame($sformatf("vec%0d", i), vecs[i].div, vecs[i].ns, 1'b1, vecs[i].h2,
                   vecs[i].ex, vecs[i].ed);
      end

      // Index wraps 2->0: fourth write lands in h0.
      wr(16'h1000);
      wr(16'h2000);
      wr(16'h3000);
      wr(16'h4000);
      run_frame("wrap", 8'd0, 16'd3, 1'b0, 16'h0000,
                {16'h4000, 16'h4000, 16'h4000}, {16'h2000, 16'h3000, 16'h4800});

      // Continuous run with a stray i_start, aborted by i_stop.
      i_div      = 8'd0;
      i_nsamples = 16'd0;
      i_start    = 1'b1;
      tick();
      i_start = 1'b0;
      k = 0;
      for (int c = 0; c < 40 && k < 12; c++) begin
         tick();
         if (o_valid) begin
            run1[k] = o_x;
            check16($sformatf("run1 x%0d", k), o_x, x_ref[k]);
            k++;
         end
         i_start = (c == 3);
      end
      i_start = 1'b0;
      check16("run1 count", 16'(k), 16'd12);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check1("stop valid", o_valid, 1'b0);
      check1("stop busy", o_busy, 1'b0);
      check1("stop ready", o_coef_ready, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check1("stop no done", o_done, 1'b0);
      end

      i_start = 1'b1;
      i_stop  = 1'b1;
      tick();
      i_start = 1'b0;
      i_stop  = 1'b0;
      check1("start+stop ignored", o_busy, 1'b0);

      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      k = 0;
      for (int c = 0; c < 40 && k < 12; c++) begin
         tick();
         if (o_valid) begin
            check16($sformatf("run2 x%0d", k), o_x, run1[k]);
            k++;
         end
      end
      check16("run2 count", 16'(k), 16'd12);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check1("stop2 no done", o_done, 1'b0);

      // Asynchronous reset in the middle of a frame.
      wr(16'h7FFF);
      wr(16'h7FFF);
      i_div        = 8'd1;
      i_nsamples   = 16'd0;
      i_coef_valid = 1'b1;
      i_coef       = 16'h7FFF;
      i_start      = 1'b1;
      tick();
      i_coef_valid = 1'b0;
      i_start      = 1'b0;
      repeat (5) tick();
      check16("pre-reset x", o_x, 16'h4000);
      check16("pre-reset d", o_d, 16'h7FFE);
      #3 rst = 1'b1;
      #1;
      check_all_zero("async reset");
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check1("ready after reset", o_coef_ready, 1'b1);
      run_frame("post-reset", 8'd0, 16'd2, 1'b0, 16'h0000,
                {16'h4000, 16'h4000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
